// File: rtl/wb_io_arbiter.sv
// Round-robin Wishbone classic arbiter for the SoC IO bus; grant is held for a whole cyc burst.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that ends stalled slave accesses with m_err_o.
module wb_io_arbiter #(
    parameter int NUM_M          = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_M*32-1:0]  m_adr_i,
    input  logic [NUM_M*32-1:0]  m_dat_i,
    input  logic [NUM_M*4-1:0]   m_sel_i,
    input  logic [NUM_M-1:0]     m_we_i,
    input  logic [NUM_M-1:0]     m_cyc_i,
    input  logic [NUM_M-1:0]     m_stb_i,
    output logic [NUM_M-1:0]     m_ack_o,
    output logic [NUM_M-1:0]     m_err_o,
    output logic [31:0]          m_dat_o,
    output logic [31:0]          s_adr_o,
    output logic [31:0]          s_dat_o,
    output logic [3:0]           s_sel_o,
    output logic                 s_we_o,
    output logic                 s_cyc_o,
    output logic                 s_stb_o,
    input  logic                 s_ack_i,
    input  logic [31:0]          s_dat_i,
    output logic [NUM_M-1:0]     grant_o,
    output logic                 busy_o
);

    localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ERR} state_e;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0]    cnt_q;
    logic [NUM_M-1:0] err_q;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_e;
`endif

    state_e           state_q;
    logic [NUM_M-1:0] grant_q;
    logic [IW-1:0]    gidx_q;
    logic [IW-1:0]    rr_ptr_q;
    logic [IW-1:0]    pick_d;
    logic             found_d;
    int               cand;

    function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
        if (int'(g) == NUM_M - 1) return '0;
        return g + 1'b1;
    endfunction

    // First requester at or after rr_ptr, wrapping modulo NUM_M.
    always_comb begin
        pick_d  = '0;
        found_d = 1'b0;
        cand    = 0;
        for (int i = 0; i < NUM_M; i++) begin
            cand = int'(rr_ptr_q) + i;
            if (cand >= NUM_M) cand = cand - NUM_M;
            if (!found_d && m_cyc_i[cand]) begin
                found_d = 1'b1;
                pick_d  = IW'(cand);
            end
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        m_ack_o = '0;
        if (state_q == BUSY) begin
            for (int k = 0; k < NUM_M; k++) begin
                if (grant_q[k]) begin
                    s_adr_o    = m_adr_i[k*32 +: 32];
                    s_dat_o    = m_dat_i[k*32 +: 32];
                    s_sel_o    = m_sel_i[k*4 +: 4];
                    s_we_o     = m_we_i[k];
                    s_cyc_o    = m_cyc_i[k];
                    s_stb_o    = m_stb_i[k];
                    m_ack_o[k] = s_ack_i & m_stb_i[k];
                end
            end
        end
        // Read data is gated so masters never see stale bus data.
        m_dat_o = (|m_ack_o) ? s_dat_i : '0;
    end

    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

`ifdef WB_ARB_TIMEOUT_EN
    assign m_err_o = err_q;
`else
    assign m_err_o = '0;
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            gidx_q   <= '0;
            rr_ptr_q <= '0;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= '0;
`endif
        end else begin
`ifdef WB_ARB_TIMEOUT_EN
            err_q <= '0;
`endif
            case (state_q)
                IDLE: begin
                    if (found_d) begin
                        state_q <= BUSY;
                        grant_q <= NUM_M'(1) << pick_d;
                        gidx_q  <= pick_d;
                    end
`ifdef WB_ARB_TIMEOUT_EN
                    cnt_q <= '0;
`endif
                end
                BUSY: begin
                    if (!m_cyc_i[gidx_q]) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr(gidx_q);
`ifdef WB_ARB_TIMEOUT_EN
                        cnt_q    <= '0;
                    end else if (m_stb_i[gidx_q] && !s_ack_i) begin
                        // An ack arriving on the limit cycle takes this branch's else path.
                        if (cnt_q == CNT_LIMIT) begin
                            state_q <= ERR;
                            err_q   <= grant_q;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= '0;
`endif
                    end
                end
`ifdef WB_ARB_TIMEOUT_EN
                ERR: begin
                    if (!m_cyc_i[gidx_q]) begin
                        state_q  <= IDLE;
                        grant_q  <= '0;
                        rr_ptr_q <= next_ptr(gidx_q);
                    end
                end
`endif
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_io_arbiter.sv
// Bench for wb_io_arbiter: directed stimulus with a queue-based scoreboard on ack/err events.
module tb_wb_io_arbiter;

    localparam int NM = 2;

    logic             clock;
    logic             reset;
    logic [NM*32-1:0] m_adr;
    logic [NM*32-1:0] m_dat;
    logic [NM*4-1:0]  m_sel;
    logic [NM-1:0]    m_we;
    logic [NM-1:0]    m_cyc;
    logic [NM-1:0]    m_stb;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [31:0]      m_dat_o;
    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic             s_cyc_o;
    logic             s_stb_o;
    logic             s_ack_i;
    logic [31:0]      s_dat_i;
    logic [NM-1:0]    grant_o;
    logic             busy_o;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [1:0]  ack;
        logic [1:0]  err;
        logic [31:0] dat;
        logic [1:0]  grant;
        logic [31:0] adr;
        logic [31:0] wdat;
        logic        we;
    } ev_t;

    ev_t exp_q[$];
    logic [31:0] ba, bd;

    wb_io_arbiter #(.NUM_M(NM), .TIMEOUT_CYCLES(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .m_adr_i (m_adr),
        .m_dat_i (m_dat),
        .m_sel_i (m_sel),
        .m_we_i  (m_we),
        .m_cyc_i (m_cyc),
        .m_stb_i (m_stb),
        .m_ack_o (m_ack_o),
        .m_err_o (m_err_o),
        .m_dat_o (m_dat_o),
        .s_adr_o (s_adr_o),
        .s_dat_o (s_dat_o),
        .s_sel_o (s_sel_o),
        .s_we_o  (s_we_o),
        .s_cyc_o (s_cyc_o),
        .s_stb_o (s_stb_o),
        .s_ack_i (s_ack_i),
        .s_dat_i (s_dat_i),
        .grant_o (grant_o),
        .busy_o  (busy_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat);
        m_cyc[k]         = cyc;
        m_stb[k]         = stb;
        m_we[k]          = we;
        m_adr[k*32 +: 32] = adr;
        m_dat[k*32 +: 32] = dat;
    endtask

    task automatic push_exp(input logic [1:0] ack, input logic [1:0] err, input logic [31:0] dat,
                            input logic [31:0] adr, input logic [31:0] wdat, input logic we);
        ev_t e;
        e.ack   = ack;
        e.err   = err;
        e.dat   = dat;
        e.grant = ack | err;
        e.adr   = adr;
        e.wdat  = wdat;
        e.we    = we;
        exp_q.push_back(e);
    endtask

    // Monitor: every ack/err the DUT raises must match the next queued expectation.
    always @(negedge clock) begin
        if (reset === 1'b1 && ((|m_ack_o) || (|m_err_o))) begin
            ev_t got;
            ev_t e;
            got.ack   = m_ack_o;
            got.err   = m_err_o;
            got.dat   = m_dat_o;
            got.grant = grant_o;
            got.adr   = s_adr_o;
            got.wdat  = s_dat_o;
            got.we    = s_we_o;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: ack=%b err=%b adr=0x%0h none expected",
                         m_ack_o, m_err_o, s_adr_o);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    n_err++;
                    $display("FAIL sb_event: got ack=%b err=%b dat=0x%0h gnt=%b adr=0x%0h wdat=0x%0h we=%b expected ack=%b err=%b dat=0x%0h gnt=%b adr=0x%0h wdat=0x%0h we=%b",
                             got.ack, got.err, got.dat, got.grant, got.adr, got.wdat, got.we,
                             e.ack, e.err, e.dat, e.grant, e.adr, e.wdat, e.we);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        reset   = 1'b0;
        m_adr   = '0;
        m_dat   = '0;
        m_sel   = '1;
        m_we    = '0;
        m_cyc   = '0;
        m_stb   = '0;
        s_ack_i = 1'b1;
        s_dat_i = 32'hFFFF_FFFF;

        // Reset state, with a stray slave ack present
        step(); step(); #2;
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_busy",  32'(busy_o),  32'h0);
        chk("rst_scyc",  32'(s_cyc_o), 32'h0);
        chk("rst_sstb",  32'(s_stb_o), 32'h0);
        chk("rst_sadr",  s_adr_o,      32'h0);
        chk("rst_mack",  32'(m_ack_o), 32'h0);
        chk("rst_merr",  32'(m_err_o), 32'h0);
        chk("rst_mdat",  m_dat_o,      32'h0);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        reset   = 1'b1;

        // Single write from master0
        step();
        set_m(0, 1, 1, 1, 32'h2000_0008, 32'h0000_00A5);
        #2;
        chk("wr_latency_scyc", 32'(s_cyc_o), 32'h0);
        step(); #2;
        chk("wr_scyc",  32'(s_cyc_o), 32'h1);
        chk("wr_grant", 32'(grant_o), 32'h1);
        chk("wr_sadr",  s_adr_o,      32'h2000_0008);
        chk("wr_sdat",  s_dat_o,      32'h0000_00A5);
        chk("wr_swe",   32'(s_we_o),  32'h1);
        chk("wr_ssel",  32'(s_sel_o), 32'hF);
        chk("wr_noack_first", 32'(m_ack_o), 32'h0);
        step();
        s_ack_i = 1'b1;
        push_exp(2'b01, 2'b00, 32'h0, 32'h2000_0008, 32'h0000_00A5, 1'b1);
        step();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        s_ack_i = 1'b0;
        #2;
        chk("wr_ack_once", 32'(m_ack_o), 32'h0);
        step(); #2;
        chk("wr_release_grant", 32'(grant_o), 32'h0);
        chk("wr_release_busy",  32'(busy_o),  32'h0);

        // Read by master1 (rr_ptr=1) while master0 waits
        set_m(1, 1, 1, 0, 32'h2000_0104, 32'h0);
        set_m(0, 1, 1, 1, 32'h2000_0010, 32'h11);
        step(); #2;
        chk("rd_grant", 32'(grant_o), 32'h2);
        chk("rd_sadr",  s_adr_o,      32'h2000_0104);
        chk("rd_swe",   32'(s_we_o),  32'h0);
        s_ack_i = 1'b1;
        s_dat_i = 32'hDEAD_BEEF;
        push_exp(2'b10, 2'b00, 32'hDEAD_BEEF, 32'h2000_0104, 32'h0, 1'b0);
        step();
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        step(); #2;
        chk("b2b_gap_busy",  32'(busy_o),  32'h0);
        chk("b2b_gap_grant", 32'(grant_o), 32'h0);
        step(); #2;
        chk("b2b_grant_m0", 32'(grant_o), 32'h1);
        chk("b2b_sadr_m0",  s_adr_o,      32'h2000_0010);

        // Burst lock: master0 keeps cyc over three acks while master1 requests
        set_m(1, 1, 1, 0, 32'h2000_0200, 32'h0);
        step();
        for (int p = 0; p < 3; p++) begin
            ba = 32'h2000_0010 + 32'(p * 4);
            bd = 32'h11 + 32'(p);
            set_m(0, 1, 1, 1, ba, bd);
            s_ack_i = 1'b1;
            push_exp(2'b01, 2'b00, 32'h0, ba, bd, 1'b1);
            #2;
            chk("burst_grant_ack", 32'(grant_o), 32'h1);
            step();
            set_m(0, 1, 0, 1, ba, bd);
            s_ack_i = 1'b0;
            #2;
            chk("burst_grant_gap", 32'(grant_o), 32'h1);
            step();
        end
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        step(); #2;
        chk("burst_release", 32'(grant_o), 32'h0);
        step(); #2;
        chk("burst_next_m1", 32'(grant_o), 32'h2);
        chk("burst_sadr_m1", s_adr_o,      32'h2000_0200);

        // Reset mid-transfer with a slave ack pending
        reset   = 1'b0;
        s_ack_i = 1'b1;
        s_dat_i = 32'h1234_5678;
        #1;
        chk("mid_rst_grant", 32'(grant_o), 32'h0);
        chk("mid_rst_busy",  32'(busy_o),  32'h0);
        chk("mid_rst_scyc",  32'(s_cyc_o), 32'h0);
        chk("mid_rst_sstb",  32'(s_stb_o), 32'h0);
        chk("mid_rst_mack",  32'(m_ack_o), 32'h0);
        chk("mid_rst_mdat",  m_dat_o,      32'h0);
        step();
        set_m(0, 1, 1, 1, 32'h2000_0020, 32'h77);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        reset   = 1'b1;
        step(); #2;
        chk("rr_after_reset_m0", 32'(grant_o), 32'h1);
        s_ack_i = 1'b1;
        push_exp(2'b01, 2'b00, 32'h0, 32'h2000_0020, 32'h77, 1'b1);
        step();
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        s_ack_i = 1'b0;
        step(); #2;
        chk("contend_gap_busy", 32'(busy_o), 32'h0);
        step(); #2;
        chk("contend_m1", 32'(grant_o), 32'h2);
        s_ack_i = 1'b1;
        s_dat_i = 32'hCAFE_F00D;
        push_exp(2'b10, 2'b00, 32'hCAFE_F00D, 32'h2000_0200, 32'h0, 1'b0);
        step();
        set_m(1, 0, 0, 0, 32'h0, 32'h0);
        s_ack_i = 1'b0;
        s_dat_i = 32'h0;
        step(); #2;
        chk("contend_release", 32'(grant_o), 32'h0);

        // Hung slave: master0 strobes, slave never acks
        set_m(0, 1, 1, 1, 32'h2000_0030, 32'h5A);
        step(); #2;
        chk("hang_grant", 32'(grant_o), 32'h1);
`ifdef WB_ARB_TIMEOUT_EN
        push_exp(2'b00, 2'b01, 32'h0, 32'h0, 32'h0, 1'b0);
        repeat (3) step();
        #2;
        chk("to_no_err_yet", 32'(m_err_o), 32'h0);
        chk("to_scyc_live",  32'(s_cyc_o), 32'h1);
        step(); #2;
        chk("to_err_pulse", 32'(m_err_o), 32'h1);
        chk("to_scyc_off",  32'(s_cyc_o), 32'h0);
        chk("to_err_busy",  32'(busy_o),  32'h1);
        step(); #2;
        chk("to_err_single", 32'(m_err_o), 32'h0);
        chk("to_scyc_held",  32'(s_cyc_o), 32'h0);
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        step(); #2;
        chk("to_idle_busy",  32'(busy_o),  32'h0);
        chk("to_idle_grant", 32'(grant_o), 32'h0);
`else
        repeat (100) step();
        #2;
        chk("hang_grant_held", 32'(grant_o), 32'h1);
        chk("hang_scyc_held",  32'(s_cyc_o), 32'h1);
        chk("hang_busy",       32'(busy_o),  32'h1);
        chk("hang_no_err",     32'(m_err_o), 32'h0);
        set_m(0, 0, 0, 0, 32'h0, 32'h0);
        step(); #2;
        chk("hang_release", 32'(grant_o), 32'h0);
`endif

        step(); step();
        chk("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/wb_io_arbiter.md
Name: wb_io_arbiter

Overview:
- Round-robin Wishbone classic arbiter sharing the SoC IO bus (wb_m2s_io_* / wb_s2m_io_*) between NUM_M masters, e.g. core data port and a debug/test master.
- Sits in rv32i_soc between the masters and the IO interconnect decoder (UART/GPIO/SPI/SPI-flash slaves).
- Grant is locked for the whole cyc burst.
- An optional watchdog terminates hung slave accesses with an error.

Parameters:
- NUM_M, 2, number of masters (2..8).
- TIMEOUT_CYCLES, 255, cycles stb may wait for ack before error termination (only with WB_ARB_TIMEOUT_EN); 8-bit counter width derived via $clog2(TIMEOUT_CYCLES+1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous active-low reset (0 = reset).
- m_adr_i  in  NUM_M*32  master addresses; master k at [32k+31:32k].
- m_dat_i  in  NUM_M*32  master write data.
- m_sel_i  in  NUM_M*4  master byte selects.
- m_we_i  in  NUM_M  write enables.
- m_cyc_i  in  NUM_M  cycle requests.
- m_stb_i  in  NUM_M  strobes.
- m_ack_o  out  NUM_M  per-master ack.
- m_err_o  out  NUM_M  per-master error (timeout).
- m_dat_o  out  32  read data, broadcast to all masters.
- s_adr_o  out  32  IO bus address.
- s_dat_o  out  32  IO bus write data.
- s_sel_o  out  4  IO bus byte selects.
- s_we_o  out  1  IO bus write enable.
- s_cyc_o  out  1  IO bus cycle.
- s_stb_o  out  1  IO bus strobe.
- s_ack_i  in  1  IO bus ack.
- s_dat_i  in  32  IO bus read data.
- grant_o  out  NUM_M  one-hot current grant; 0 when idle.
- busy_o  out  1  1 when state != IDLE.

Behaviour:
- States: IDLE, BUSY, ERR; state, grant and RR pointer (rr_ptr, init 0) are registered.
- Reset (async, reset=0):
  - state=IDLE, grant=0, rr_ptr=0, counter=0.
  - All outputs 0, including m_dat_o: it is data-gated by any m_ack_o.
  - Reset mid-transfer aborts immediately; no ack or err is issued.
- IDLE: if any m_cyc_i=1, pick the first requesting index at or after rr_ptr (modulo NUM_M), register grant one-hot, go BUSY. Arbitration latency is 1 cycle: s_cyc_o first high the cycle after m_cyc_i is seen.
- BUSY:
  - s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o = granted master's signals, combinational mux.
  - m_ack_o[g] = s_ack_i & m_stb_i[g]; other acks 0.
  - m_dat_o = s_dat_i while ack, else 0.
  - When m_cyc_i[g]=0: go IDLE, grant=0, rr_ptr=(g+1)%NUM_M.
- Non-granted requesters wait; their cyc/stb never reach the bus.
- Back-to-back: after release there is exactly one IDLE cycle before the next grant, even if the other master already requests.
- Simultaneous requests from IDLE resolve strictly by rr_ptr order. Same master re-requesting is served only after others at/after rr_ptr.
- Multiple stb phases within one held cyc (burst) stay on the same grant.
- s_ack_i while in IDLE or ERR is ignored: no m_ack_o.
- In IDLE all s_* outputs are 0.

Optional Feature:
- Macro WB_ARB_TIMEOUT_EN.
- Defined:
  - Counter increments each BUSY cycle with s_stb_o=1 and s_ack_i=0; clears on ack, on stb low, or on leaving BUSY.
  - When counter==TIMEOUT_CYCLES-1 without ack: m_err_o[g]=1 for exactly one cycle (the next cycle), state -> ERR.
  - ERR: s_cyc_o=s_stb_o=0, m_ack_o=0. Wait for m_cyc_i[g]=0, then IDLE and advance rr_ptr as normal.
  - An ack in the same cycle the limit is reached wins: normal ack, no err.
- Undefined: counter and ERR state absent; m_err_o tied 0; a hung slave holds the grant indefinitely.

Test Plan:
- Single write: master0 cyc/stb/we=1, adr=0x2000_0008, dat=0xA5 for 2 cycles; slave acks on the 2nd bus cycle -> s_cyc_o rises 1 cycle after request, s_dat_o=0xA5, m_ack_o=2'b01 for one cycle, grant_o returns to 0 after cyc drops.
- Contention: both masters raise cyc in the same cycle from reset -> master0 served first, one IDLE gap, then master1. Repeat with both requesting -> master1 served first (rr_ptr=1).
- Read routing: master1 read, s_dat_i=0xDEADBEEF with ack -> m_dat_o=0xDEADBEEF, m_ack_o=2'b10. master0 sees no ack.
- Burst lock: master0 holds cyc over 3 stb/ack phases while master1 requests -> grant stays 2'b01 for all 3 acks; master1 is granted only after master0 drops cyc.
- Timeout (WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): slave never acks -> m_err_o[0] pulses one cycle after 4 stalled cycles, s_cyc_o=0 thereafter, IDLE after master drops cyc. Without the macro, grant is still held after 100 cycles.
- Reset mid-transfer: reset=0 while BUSY -> all outputs 0 the same cycle, no ack/err; after release, a fresh request arbitrates from rr_ptr=0.
